// File: rtl/program_loader.sv
// UART (8N1) boot loader: receives a length-prefixed stream of 16-bit words and writes
// them to RAM from address 0, holding the CPU in reset until the whole image has landed.
module program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       loaded_count
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR} state_t;

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t         rx_state_q, rx_state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err_q, frame_err_d;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              wren_q, wren_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Receiver: start on a synced falling edge, re-check mid start bit, then sample mid-bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    case (state_q)
      LEN_HI: begin
        if (frame_err_q) state_d = ERR;
        else if (byte_valid_q) begin
          len_d[15:8] = shift_q;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (frame_err_q) state_d = ERR;
        else if (byte_valid_q) begin
          len_d[7:0] = shift_q;
          state_d    = ({len_q[15:8], shift_q} == 16'd0) ? DONE : DATA_HI;
        end
      end
      DATA_HI: begin
        if (frame_err_q) state_d = ERR;
        else if (byte_valid_q) begin
          hi_d    = shift_q;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (frame_err_q) state_d = ERR;
        else if (byte_valid_q) begin
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = {hi_q, shift_q};
          wren_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = count_q + 16'd1;
        state_d = (count_q + 16'd1 == len_q) ? DONE : DATA_HI;
      end
      default: begin
        if (load_req) begin
          count_d = '0;
          state_d = LEN_HI;
        end
      end
    endcase
    // Status flags are registered from the next state so they line up with state_q.
    busy_d    = (state_d != DONE) && (state_d != ERR);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
    cpu_rst_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= LEN_HI;
      len_q        <= '0;
      hi_q         <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      cpu_rst_q    <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
  assign ram_wren     = wren_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign loaded_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Drives UART frames into program_loader and checks RAM writes and status against a word-list model.
module tb_program_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;

  typedef logic [15:0] wq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          load_req = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data;
  logic          ram_wren, cpu_rst, busy, done, err;
  logic [15:0]   loaded_count;

  int tests = 0;
  int fails = 0;
  int inv_viol = 0;
  logic armed = 1'b0;
  logic wren_prev = 1'b0;
  logic [AW+15:0] obs_q[$];
  logic [AW+15:0] exp_q[$];

  program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .load_req(load_req),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
    .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  // Observe writes and status invariants on the falling edge.
  always @(negedge clk) begin
    if (ram_wren === 1'b1) obs_q.push_back({ram_addr, ram_data});
    if (armed) begin
      if ((int'(busy) + int'(done) + int'(err)) != 1) inv_viol <= inv_viol + 1;
      if (cpu_rst !== done) inv_viol <= inv_viol + 1;
      if (ram_wren && wren_prev) inv_viol <= inv_viol + 1;
    end
    wren_prev <= ram_wren;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_flag(input string tag, input bit want_err);
    int k = 0;
    while (((want_err ? err : done) !== 1'b1) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, want_err ? err : done, 1);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_wren"}, ram_wren, 0);
    chk({tag, "_cpurst"}, cpu_rst, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_count"}, loaded_count, 0);
  endtask

  // Model: word i of the image lands at address i mod 2^AW.
  task automatic do_frame(input string tag, input wq_t w);
    logic [15:0] n;
    n = 16'(w.size());
    for (int i = 0; i < w.size(); i++)
      exp_q.push_back({AW'(i % (1 << AW)), w[i]});
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
    for (int i = 0; i < w.size(); i++) begin
      send_byte(w[i][15:8], 1'b1);
      send_byte(w[i][7:0], 1'b1);
    end
    wait_flag({tag, "_done"}, 1'b0);
    repeat (2) @(negedge clk);
    compare_writes(tag);
    chk({tag, "_count"}, loaded_count, 32'(w.size()));
    chk({tag, "_cpurst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t w;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    armed = 1'b1;

    w = '{16'h1234, 16'hABCD};
    do_frame("two_words", w);

    // Empty image: done right after the length bytes, no writes.
    pulse_load_req();
    chk("reload_busy", busy, 1);
    chk("reload_cpurst", cpu_rst, 0);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    chk("empty_mid_done", done, 0);
    send_byte(8'h00, 1'b1);
    wait_flag("empty_done", 1'b0);
    chk("empty_cpurst", cpu_rst, 1);
    compare_writes("empty");

    // Framing error in the first data byte.
    pulse_load_req();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_flag("ferr_err", 1'b1);
    chk("ferr_cpurst", cpu_rst, 0);
    chk("ferr_busy", busy, 0);
    send_byte(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    chk("ferr_sticky", err, 1);
    compare_writes("ferr");
    pulse_load_req();
    chk("ferr_clear", err, 0);
    w = '{16'hBEEF};
    do_frame("after_err", w);

    // Short low glitch must not be taken as a start bit.
    pulse_load_req();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy", busy, 1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    chk("glitch_mid_done", done, 0);
    send_byte(8'h00, 1'b1);
    wait_flag("glitch_done", 1'b0);
    compare_writes("glitch");

    // load_req during DATA_LO is ignored.
    pulse_load_req();
    exp_q.push_back({AW'(0), 16'hABCD});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAB, 1'b1);
    repeat (3) @(negedge clk);
    pulse_load_req();
    send_byte(8'hCD, 1'b1);
    wait_flag("ldreq_done", 1'b0);
    repeat (2) @(negedge clk);
    compare_writes("ldreq");
    chk("ldreq_count", loaded_count, 1);

    // Reset mid-byte of the second word of a 3-word load.
    pulse_load_req();
    exp_q.push_back({AW'(0), 16'h1111});
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    chk("midrst_precount", loaded_count, 1);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("midrst");
    compare_writes("midrst_pre");
    rst = 1'b1;
    w = '{16'h0007};
    do_frame("after_rst", w);

    // Random images, some longer than the address space so addresses wrap.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      pulse_load_req();
      do_frame($sformatf("rand%0d", r), w);
    end

    chk("invariants", inv_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
